// File: rtl/bram_cam.sv
// bram_cam: block-RAM content-addressable memory.
// The key is split into slices. Each slice has its own dual-port RAM, indexed by the slice value.
// Bit i of a row marks that entry i holds that slice value.
// A search ANDs the port-A rows of all slices and priority-encodes the result.
// Writes and deletes update port B with read-modify-write.
// A shadow RAM remembers each entry's old value so that it can be removed first.
//
// Handshake: write_enable is sampled only on an edge where the block is idle
// (write_busy low). That edge captures write_addr/write_data/write_delete.
// write_busy stays high until the operation is complete. There is no ready
// back-pressure; a request made while busy is dropped.
module bram_cam #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int SLICE_WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      write_addr,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       write_delete,
    input  logic                       write_enable,
    output logic                       write_busy,
    input  logic [DATA_WIDTH-1:0]      compare_data,
    output logic [2**ADDR_WIDTH-1:0]   match_many,
    output logic [2**ADDR_WIDTH-1:0]   match_single,
    output logic [ADDR_WIDTH-1:0]      match_addr,
    output logic                       match
);

    localparam int RAM_DEPTH   = 2**ADDR_WIDTH;
    localparam int SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DELETE_1,
        ST_DELETE_2,
        ST_WRITE_1,
        ST_WRITE_2
    } state_t;

    // Source of the port-B row address in every slice
    typedef enum logic [1:0] {
        B_SRC_CNT,
        B_SRC_SHADOW,
        B_SRC_DATA
    } b_src_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [SLICE_WIDTH-1:0]   r_cnt;
    logic                     r_busy;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic                     r_delete;

    b_src_t                   w_b_src;
    logic                     w_b_we;
    logic [RAM_DEPTH-1:0]     w_clr;
    logic [RAM_DEPTH-1:0]     w_set;
    logic                     w_shadow_we;
    logic [RAM_DEPTH-1:0]     w_onehot;

    logic [DATA_WIDTH-1:0]    r_shadow [0:RAM_DEPTH-1];
    logic [DATA_WIDTH-1:0]    r_shadow_q;
    logic [ADDR_WIDTH-1:0]    w_shadow_raddr;

    logic [RAM_DEPTH-1:0]     w_slice_q [SLICE_COUNT];
    logic [RAM_DEPTH-1:0]     w_match_many;
    logic [ADDR_WIDTH-1:0]    w_match_addr;
    logic [RAM_DEPTH-1:0]     w_match_single;

    assign w_onehot = {{(RAM_DEPTH-1){1'b0}}, 1'b1} << r_addr;

    // State register; reset restarts the match-RAM clear sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:     w_next = (r_cnt == '0) ? ST_IDLE : ST_INIT;
            ST_IDLE:     w_next = write_enable ? ST_DELETE_1 : ST_IDLE;
            ST_DELETE_1: w_next = ST_DELETE_2;
            ST_DELETE_2: w_next = r_delete ? ST_IDLE : ST_WRITE_1;
            ST_WRITE_1:  w_next = ST_WRITE_2;
            ST_WRITE_2:  w_next = ST_IDLE;
            default:     w_next = ST_INIT;
        endcase
    end

    // Per-state controls for the port-B read-modify-write and the shadow write
    always_comb begin
        w_b_src     = B_SRC_DATA;
        w_b_we      = 1'b0;
        w_clr       = '0;
        w_set       = '0;
        w_shadow_we = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_b_src = B_SRC_CNT;
                w_b_we  = 1'b1;
                w_clr   = '1;
            end
            ST_DELETE_1: begin
                w_b_src = B_SRC_SHADOW;
            end
            ST_DELETE_2: begin
                w_b_src     = B_SRC_SHADOW;
                w_b_we      = 1'b1;
                w_clr       = w_onehot;
                w_shadow_we = !r_delete;
            end
            ST_WRITE_2: begin
                w_b_we = 1'b1;
                w_set  = w_onehot;
            end
            default: ;
        endcase
    end

    // Busy is registered from the next state so it falls on the edge entering idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b1;
        end else begin
            r_busy <= (w_next != ST_IDLE);
        end
    end

    assign write_busy = r_busy;

    // Init row counter: walks every slice row from the top down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '1;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Request capture; only idle cycles update it, so requests while busy are dropped
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE) begin
            r_addr   <= write_addr;
            r_data   <= write_data;
            r_delete <= write_delete;
        end
    end

    // While idle, prefetch the old value of the entry that may be written next
    assign w_shadow_raddr = (r_state == ST_IDLE) ? write_addr : r_addr;

    // Shadow RAM; a write is forwarded into the read register
    always_ff @(posedge clk) begin
        if (w_shadow_we) begin
            r_shadow[r_addr] <= r_data;
            r_shadow_q       <= r_data;
        end else begin
            r_shadow_q <= r_shadow[w_shadow_raddr];
        end
    end

    for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
        localparam int W  = (s == SLICE_COUNT - 1) ?
                            DATA_WIDTH - SLICE_WIDTH * (SLICE_COUNT - 1) : SLICE_WIDTH;
        localparam int LO = s * SLICE_WIDTH;

        logic [RAM_DEPTH-1:0] r_mem [0:(2**W)-1];
        logic [W-1:0]         w_addr_a;
        logic [W-1:0]         w_addr_b;
        logic [RAM_DEPTH-1:0] r_q_a;
        logic [RAM_DEPTH-1:0] r_q_b;

        assign w_addr_a = compare_data[LO +: W];

        // Port-B row: init counter, the entry's old value, or its new value
        always_comb begin
            w_addr_b = r_data[LO +: W];
            case (w_b_src)
                B_SRC_CNT:    w_addr_b = r_cnt[W-1:0];
                B_SRC_SHADOW: w_addr_b = r_shadow_q[LO +: W];
                default:      w_addr_b = r_data[LO +: W];
            endcase
        end

        // Port A: registered search read; it sees old data on a same-row write
        always_ff @(posedge clk) begin
            r_q_a <= r_mem[w_addr_a];
        end

        // Port B: registered read, plus the write-back of the modified row
        always_ff @(posedge clk) begin
            if (w_b_we) begin
                r_mem[w_addr_b] <= (r_q_b & ~w_clr) | w_set;
            end
            r_q_b <= r_mem[w_addr_b];
        end

        assign w_slice_q[s] = r_q_a;
    end

    // An entry matches only if every slice agrees
    always_comb begin
        w_match_many = '1;
        for (int s = 0; s < SLICE_COUNT; s++) begin
            w_match_many = w_match_many & w_slice_q[s];
        end
    end

    // LSB-priority encoder: scanning downward leaves the lowest index last
    always_comb begin
        w_match_addr   = '0;
        w_match_single = '0;
        for (int i = RAM_DEPTH - 1; i >= 0; i--) begin
            if (w_match_many[i]) begin
                w_match_addr = ADDR_WIDTH'(i);
            end
        end
        if (|w_match_many) begin
            w_match_single[w_match_addr] = 1'b1;
        end
    end

    assign match_many   = w_match_many;
    assign match_single = w_match_single;
    assign match_addr   = w_match_addr;
    assign match        = |w_match_many;

endmodule

// File: tb/tb_bram_cam.sv
// tb_bram_cam: directed and randomised checks of bram_cam against a table model.
module tb_bram_cam;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int SW    = 9;
    localparam int DEPTH = 32;
    localparam int INIT_CYCLES = 512;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     write_addr = '0;
    logic [DW-1:0]     write_data = '0;
    logic              write_delete = 1'b0;
    logic              write_enable = 1'b0;
    logic              write_busy;
    logic [DW-1:0]     compare_data = '0;
    logic [DEPTH-1:0]  match_many;
    logic [DEPTH-1:0]  match_single;
    logic [AW-1:0]     match_addr;
    logic              match;

    int n_tests = 0;
    int n_fail  = 0;

    // clock
    always #5 clk = ~clk;

    bram_cam #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_delete (write_delete),
        .write_enable (write_enable),
        .write_busy   (write_busy),
        .compare_data (compare_data),
        .match_many   (match_many),
        .match_single (match_single),
        .match_addr   (match_addr),
        .match        (match)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [DEPTH-1:0] m);
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    // ---------------- behavioural model ----------------
    // The table holds what a search sees: each entry's value and whether it is valid.
    // An operation accepted at edge E removes the old value at E+2.
    // A write makes its new value visible from E+4.
    logic [DW-1:0]    m_val   [DEPTH];
    bit               m_valid [DEPTH];
    bit               started = 0;
    int               init_left = 0;
    bit               op_active = 0;
    int               op_k = 0;
    logic [AW-1:0]    op_addr;
    logic [DW-1:0]    op_data;
    bit               op_del;
    bit               exp_busy = 1;
    logic [DEPTH-1:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            started   = 1;
            init_left = INIT_CYCLES;
            op_active = 0;
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
            exp_q.delete();
        end else if (started) begin
            if (init_left == 0) begin
                logic [DEPTH-1:0] e;
                for (int i = 0; i < DEPTH; i++) e[i] = m_valid[i] && (m_val[i] == compare_data);
                exp_q.push_back(e);
            end
            if (init_left > 0) begin
                init_left--;
            end else if (op_active) begin
                op_k++;
                if (op_k == 2) begin
                    m_valid[op_addr] = 0;
                    if (op_del) op_active = 0;
                end else if (op_k == 4) begin
                    m_valid[op_addr] = 1;
                    m_val[op_addr]   = op_data;
                    op_active        = 0;
                end
            end else if (write_enable) begin
                op_active = 1;
                op_k      = 0;
                op_addr   = write_addr;
                op_data   = write_data;
                op_del    = write_delete;
            end
        end
        exp_busy = (init_left != 0) || op_active || rst;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started) begin
            check("busy", {63'd0, write_busy}, {63'd0, exp_busy});
            if (exp_q.size() > 0) begin
                logic [DEPTH-1:0] e;
                logic [DEPTH-1:0] s;
                e = exp_q.pop_front();
                s = '0;
                if (e != '0) s[lowest(e)] = 1'b1;
                check("match_many", 64'(match_many), 64'(e));
                check("match", {63'd0, match}, {63'd0, (e != '0)});
                check("match_addr", 64'(match_addr), 64'(lowest(e)));
                check("match_single", 64'(match_single), 64'(s));
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [DW-1:0] pool [8];
    bit rand_keys = 0;

    task automatic tick();
        @(negedge clk);
        if (rand_keys) begin
            if ($urandom_range(0, 4) == 0) compare_data = {$urandom, $urandom};
            else compare_data = pool[$urandom_range(0, 7)];
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (write_busy === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        if (n >= 1000) check("wait_idle_timeout", 64'(n), 64'd0);
    endtask

    task automatic do_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit del, input bit poke);
        int n = 0;
        wait_idle();
        write_addr   = a;
        write_data   = d;
        write_delete = del;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        while (write_busy === 1'b1 && n < 20) begin
            n++;
            if (poke && n == 1) begin
                write_enable = 1'b1;
                write_addr   = AW'($urandom);
                write_data   = pool[$urandom_range(0, 7)];
                write_delete = 1'($urandom);
            end else begin
                write_enable = 1'b0;
            end
            tick();
        end
        write_enable = 1'b0;
        check("op_busy_cycles", 64'(n), del ? 64'd2 : 64'd4);
    endtask

    task automatic search(input logic [DW-1:0] key, input logic [DEPTH-1:0] e_many,
                          input logic [AW-1:0] e_addr, input logic [DEPTH-1:0] e_single);
        compare_data = key;
        tick();
        check("lit_many", 64'(match_many), 64'(e_many));
        check("lit_addr", 64'(match_addr), 64'(e_addr));
        check("lit_single", 64'(match_single), 64'(e_single));
        check("lit_match", {63'd0, match}, {63'd0, (e_many != '0)});
    endtask

    task automatic reset_and_count();
        int n = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        while (write_busy === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        check("init_busy_cycles", 64'(n), 64'(INIT_CYCLES));
    endtask

    task automatic report();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    // watchdog
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        report();
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        pool[0] = 64'h0;
        pool[1] = 64'h1234;
        pool[2] = 64'h5678;
        pool[3] = {$urandom, $urandom};
        pool[4] = {pool[3][63:9], ~pool[3][8], pool[3][7:0]};
        pool[5] = {~pool[3][63], pool[3][62:0]};
        pool[6] = 64'h8000_0000_0000_0000;
        pool[7] = {$urandom, $urandom};

        rst = 1'b1;
        tick();
        reset_and_count();
        repeat (8) tick();
        search(64'h0, '0, '0, '0);

        do_op(5'd3, 64'h1234, 1'b0, 1'b0);
        search(64'h1234, 32'h8, 5'd3, 32'h8);
        do_op(5'd7, 64'h1234, 1'b0, 1'b0);
        search(64'h1234, 32'h88, 5'd3, 32'h08);
        do_op(5'd3, 64'h5678, 1'b0, 1'b0);
        search(64'h1234, 32'h80, 5'd7, 32'h80);
        search(64'h5678, 32'h08, 5'd3, 32'h08);
        do_op(5'd7, 64'h0, 1'b1, 1'b0);
        search(64'h1234, '0, '0, '0);
        search(64'h0, '0, '0, '0);
        do_op(5'd9, 64'h0, 1'b0, 1'b0);
        search(64'h0, 32'h200, 5'd9, 32'h200);
        do_op(5'd31, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        search(64'h8000_0000_0000_0000, 32'h8000_0000, 5'd31, 32'h8000_0000);
        search(64'h0, 32'h200, 5'd9, 32'h200);
        do_op(5'd0, 64'h5678, 1'b0, 1'b1);
        search(64'h5678, 32'h09, 5'd0, 32'h01);

        // reset in the middle of a write, with an extra request while busy
        wait_idle();
        write_addr   = 5'd5;
        write_data   = 64'hABC;
        write_delete = 1'b0;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        tick();
        write_addr   = 5'd6;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        reset_and_count();
        search(64'h1234, '0, '0, '0);
        search(64'h5678, '0, '0, '0);
        search(64'hABC, '0, '0, '0);
        search(64'h0, '0, '0, '0);
        search(64'h8000_0000_0000_0000, '0, '0, '0);

        // randomised operations, searches checked every cycle by the model
        rand_keys = 1;
        for (int it = 0; it < 120; it++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 5) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            do_op(a, pool[$urandom_range(0, 7)], ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_keys = 0;
        repeat (4) tick();

        report();
        $finish;
    end

endmodule
